grf_operand_file: RTL and testbench
===================================

Name: grf_operand_file

Overview:
- General-purpose register file, one stage upstream of the ALU.
- Supplies the ALU operands A and B from read ports RD1/RD2 and accepts the ALU result C back on the write port.
- 32 × 32-bit registers; register 0 is hardwired to zero.
- Optional write-to-read bypass, so a result written in cycle N is readable in cycle N without a stall.

Parameters:
- DATA_W, 32, register and port data width; must match the ALU operand width.
- ADDR_W, 5, register address width; the file holds 2**ADDR_W registers.
- BYPASS, 1, 1 = a read of the register being written returns WD in the same cycle; 0 = old value until the edge.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; clears every register on the clock edge
- WE  input  1  write enable
- A1  input  ADDR_W  read address, port 1 (drives ALU A)
- A2  input  ADDR_W  read address, port 2 (drives ALU B)
- A3  input  ADDR_W  write address
- WD  input  DATA_W  write data (ALU result C)
- RD1  output  DATA_W  read data, port 1
- RD2  output  DATA_W  read data, port 2

Behaviour:
- Storage: reg[1..2**ADDR_W-1], each DATA_W bits. reg[0] has no storage; reads of address 0 always return 0.
- Reset:
  - Clock is clk; reset is synchronous and active-high.
  - On a rising edge with reset=1, every register becomes 0.
  - reset dominates WE in the same cycle: no write occurs.
  - Reset value of RD1/RD2 after the reset edge: 0 for every address.
- Write:
  - On a rising edge with reset=0, WE=1 and A3≠0: reg[A3] ← WD.
  - WE=1 with A3=0 is silently ignored.
  - Write latency is 1 edge.
- Read:
  - Purely combinational from A1/A2 and the register contents; 0-cycle latency.
  - Both ports are independent; A1=A2 is legal and returns identical data.
- Bypass (BYPASS=1):
  - RDx = WD when WE=1, reset=0, A3≠0 and Ax=A3; otherwise RDx = reg[Ax].
  - Bypass is suppressed while reset=1 (RD shows stored value, which is 0 after reset).
  - Bypass is never applied for address 0.
- BYPASS=0: RDx = reg[Ax] always; a new value appears only after the write edge.
- Simultaneous events:
  - Write and read of the same register in one cycle resolve per BYPASS.
  - Write to one register and read of another are unaffected by each other.
- Reset mid-operation: an in-flight write in the reset cycle is lost; the next cycle may write normally.
- No X propagation: outputs are defined for every address once reset has been applied once.
- Sequential logic updates only on clk; no latches.

Decomposition:
- Shared package grf_pkg:
  - REG_ZERO = 0 and NUM_REGS = 2**ADDR_W.
  - A DATA_W-wide word type, shared with the ALU operand/result ports.
- One sub-module is natural: grf_read_port.
  - Inputs: address, storage array slice, WE, A3, WD, reset.
  - Output: RD.
  - Implements zero-register and bypass muxing.
  - Instantiated twice (RD1, RD2) so both ports are provably identical.
- The storage array and write logic stay in the top module.

Test Plan:
- Reset then read: pulse reset one cycle; then A1=5, A2=31 → RD1=0, RD2=0.
- Basic write/read: WE=1, A3=3, WD=32'hBDBDBDBD for one edge; then WE=0, A1=3 → RD1=32'hBDBDBDBD; A2=3 simultaneously → RD2=32'hBDBDBDBD.
- Zero register: WE=1, A3=0, WD=32'hFFFFFFFF for one edge; A1=0 → RD1=0 both before and after the edge, with no bypass.
- Bypass: reg[7]=32'h1; same cycle WE=1, A3=7, WD=32'h2, A1=7, A2=8 → RD1=32'h2 when BYPASS=1 (32'h1 when BYPASS=0); after the edge RD1=32'h2 in both builds, and RD2 is unchanged.
- Reset beats write: reg[4]=32'hA; cycle with reset=1, WE=1, A3=4, WD=32'hB → after the edge RD(A=4)=0, never 32'hB.
- ALU loopback: write reg[1]=32'hBDBDBDBD and reg[2]=32'd2; drive A1=1, A2=2 into an ALU instance with ALUOp=3'b101; write C back to A3=9 → reg[9] equals the ALU's expected result for that op.

Source files
------------

// File: rtl/grf_pkg.sv
// Shared constants and word type for the general-purpose register file and its ALU neighbours.
package grf_pkg;

  localparam int GRF_DATA_W = 32;
  localparam int GRF_ADDR_W = 5;
  localparam int NUM_REGS   = 2 ** GRF_ADDR_W;
  localparam int REG_ZERO   = 0;

  typedef logic [GRF_DATA_W-1:0] word_t;

endpackage : grf_pkg

// File: rtl/grf_read_port.sv
// One combinational read port: zero-register forcing plus optional write-to-read bypass.
module grf_read_port
  import grf_pkg::*;
#(
  parameter int DATA_W = GRF_DATA_W,
  parameter int ADDR_W = GRF_ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] regs [1:(2**ADDR_W)-1],
  input  logic              we,
  input  logic [ADDR_W-1:0] a3,
  input  logic [DATA_W-1:0] wd,
  input  logic              reset,
  output logic [DATA_W-1:0] rd
);

  logic is_zero;
  logic bypass_hit;

  assign is_zero    = (addr == ADDR_W'(REG_ZERO));
  // A reset cycle never forwards WD, so RD shows the stored value until the clear lands.
  assign bypass_hit = (BYPASS != 0) && we && !reset && (a3 == addr);

  // NOTE: rd gets a default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    rd = '0;
    if (!is_zero) begin
      if (bypass_hit) rd = wd;
      else            rd = regs[addr];
    end
  end

endmodule : grf_read_port

// File: rtl/grf_operand_file.sv
// 2**ADDR_W x DATA_W register file feeding ALU operands A/B; register 0 reads as zero.
module grf_operand_file
  import grf_pkg::*;
#(
  parameter int DATA_W = GRF_DATA_W,
  parameter int ADDR_W = GRF_ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              WE,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2
);

  localparam int NREGS = 2 ** ADDR_W;

  // Register 0 has no storage at all; the read ports synthesise its zero.
  logic [DATA_W-1:0] regs [1:NREGS-1];

  // NOTE: the array is cleared on reset because reads must be defined for every address
  //       afterwards; state updates use non-blocking assignments so all ports see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < NREGS; i++) regs[i] <= '0;
    end else if (WE && (A3 != ADDR_W'(REG_ZERO))) begin
      regs[A3] <= WD;
    end
  end

  grf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rd1 (
    .addr  (A1),
    .regs  (regs),
    .we    (WE),
    .a3    (A3),
    .wd    (WD),
    .reset (reset),
    .rd    (RD1)
  );

  grf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rd2 (
    .addr  (A2),
    .regs  (regs),
    .we    (WE),
    .a3    (A3),
    .wd    (WD),
    .reset (reset),
    .rd    (RD2)
  );

endmodule : grf_operand_file

// File: tb/tb_grf_operand_file.sv
// Self-checking bench: bypass and non-bypass builds side by side against an array model.
module tb_grf_operand_file;
  import grf_pkg::*;

  localparam int AW = GRF_ADDR_W;

  logic          clk = 1'b0;
  logic          reset;
  logic          WE;
  logic [AW-1:0] A1, A2, A3;
  word_t         WD;
  word_t         rd1_b1, rd2_b1, rd1_b0, rd2_b0;

  int checks = 0;
  int errors = 0;

  word_t model [NUM_REGS];
  bit    model_valid = 1'b0;

  always #5 clk = ~clk;

  grf_operand_file #(.BYPASS(1)) dut_b1 (
    .clk(clk), .reset(reset), .WE(WE), .A1(A1), .A2(A2), .A3(A3), .WD(WD),
    .RD1(rd1_b1), .RD2(rd2_b1)
  );

  grf_operand_file #(.BYPASS(0)) dut_b0 (
    .clk(clk), .reset(reset), .WE(WE), .A1(A1), .A2(A2), .A3(A3), .WD(WD),
    .RD1(rd1_b0), .RD2(rd2_b0)
  );

  task automatic check(input string name, input word_t actual, input word_t expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, actual, expected, $time);
    end
  endtask

  // What a read must return: zero for address 0, WD on a live bypass hit, else the stored word.
  function automatic word_t expect_rd(input logic [AW-1:0] addr, input bit byp);
    if (addr == 0) return '0;
    if (byp && WE && !reset && A3 == addr) return WD;
    return model[addr];
  endfunction

  // Stand-in ALU for the loopback test: op 3'b101 is a logical left shift A << B[4:0].
  function automatic word_t alu(input word_t a, input word_t b, input logic [2:0] op);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b101:  return a << b[4:0];
      3'b110:  return a - b;
      default: return '0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) model[i] <= '0;
      model_valid <= 1'b1;
    end else if (WE && A3 != 0) begin
      model[A3] <= WD;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("cmp_rd1_byp",   rd1_b1, expect_rd(A1, 1'b1));
      check("cmp_rd2_byp",   rd2_b1, expect_rd(A2, 1'b1));
      check("cmp_rd1_nobyp", rd1_b0, expect_rd(A1, 1'b0));
      check("cmp_rd2_nobyp", rd2_b0, expect_rd(A2, 1'b0));
    end
  end

  // Advance to just after the next rising edge; inputs then change well clear of it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  initial begin
    word_t c;
    reset = 1'b1; WE = 1'b0; A1 = '0; A2 = '0; A3 = '0; WD = '0;
    cyc();

    // Reset then read
    reset = 1'b0; A1 = 5; A2 = 31;
    settle();
    check("reset_rd1", rd1_b1, 32'h0);
    check("reset_rd2", rd2_b1, 32'h0);
    check("reset_rd2_nobyp", rd2_b0, 32'h0);

    // Basic write/read
    WE = 1'b1; A3 = 3; WD = 32'hBDBDBDBD; A1 = 3;
    settle();
    check("wr3_same_cycle_byp",   rd1_b1, 32'hBDBDBDBD);
    check("wr3_same_cycle_nobyp", rd1_b0, 32'h0);
    cyc();
    WE = 1'b0; A1 = 3; A2 = 3;
    settle();
    check("rd3_port1", rd1_b1, 32'hBDBDBDBD);
    check("rd3_port2", rd2_b0, 32'hBDBDBDBD);

    // Zero register
    WE = 1'b1; A3 = 0; WD = 32'hFFFFFFFF; A1 = 0;
    settle();
    check("zero_before_edge", rd1_b1, 32'h0);
    cyc();
    WE = 1'b0;
    settle();
    check("zero_after_edge", rd1_b1, 32'h0);

    // Bypass
    WE = 1'b1; A3 = 7; WD = 32'h1;
    cyc();
    WD = 32'h2; A1 = 7; A2 = 8;
    settle();
    check("byp_rd1_byp",   rd1_b1, 32'h2);
    check("byp_rd1_nobyp", rd1_b0, 32'h1);
    check("byp_rd2_other", rd2_b1, 32'h0);
    cyc();
    WE = 1'b0;
    settle();
    check("byp_after_byp",   rd1_b1, 32'h2);
    check("byp_after_nobyp", rd1_b0, 32'h2);

    // Reset beats write
    WE = 1'b1; A3 = 4; WD = 32'hA;
    cyc();
    reset = 1'b1; WD = 32'hB; A1 = 4; A2 = 7;
    settle();
    check("rst_cycle_no_bypass", rd1_b1, 32'hA);
    cyc();
    reset = 1'b0; WE = 1'b0;
    settle();
    check("rst_beats_write", rd1_b1, 32'h0);
    check("rst_clears_r7",   rd2_b0, 32'h0);
    WE = 1'b1; A3 = 4; WD = 32'hC;
    cyc();
    WE = 1'b0;
    settle();
    check("write_after_reset", rd1_b0, 32'hC);

    // ALU loopback
    WE = 1'b1; A3 = 1; WD = 32'hBDBDBDBD;
    cyc();
    A3 = 2; WD = 32'd2;
    cyc();
    WE = 1'b0; A1 = 1; A2 = 2;
    settle();
    c = alu(rd1_b1, rd2_b1, 3'b101);
    cyc();
    WE = 1'b1; A3 = 9; WD = c;
    cyc();
    WE = 1'b0; A1 = 9;
    settle();
    check("alu_loopback_r9", rd1_b1, 32'hF6F6F6F4);

    // Fill every register, then sweep reads on both ports
    for (int i = 1; i < NUM_REGS; i++) begin
      WE = 1'b1; A3 = AW'(i); WD = (32'h01010101 * i) ^ 32'hA5A5A5A5;
      A1 = AW'(i); A2 = AW'(NUM_REGS - i);
      cyc();
    end
    WE = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      A1 = AW'(i); A2 = AW'(NUM_REGS - 1 - i);
      cyc();
    end
    A1 = 31;
    settle();
    check("fill_r31", rd1_b0, (32'h01010101 * 31) ^ 32'hA5A5A5A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_grf_operand_file
